// File: rtl/cube_pkg.sv
// Shared definitions for the cube move scheduler: move encoding, FSM states,
// LFSR reset value and small move helpers.
package cube_pkg;

  localparam int MOVE_W   = 4;
  localparam int FACE_MSB = 3;
  localparam int FACE_LSB = 1;
  localparam int DIR_BIT  = 0;

  typedef logic [MOVE_W-1:0] move_t;

  // Codes 0..11 are real moves; 12..15 are invalid.
  localparam move_t N_MOVES   = 4'd12;
  localparam move_t MOVE_NONE = 4'hF;

  localparam logic [7:0] LFSR_RST = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT_VB,
    S_ISSUE,
    S_WAIT_DONE
  } state_e;

  function automatic logic move_valid(input move_t m);
    return m < N_MOVES;
  endfunction

  // Undoing a quarter turn is the same face in the other direction.
  function automatic move_t move_inv(input move_t m);
    return m ^ move_t'(1);
  endfunction

endpackage

// File: rtl/cube_move_if.sv
// Board-side and rotation-engine-side signals of the move scheduler.
// master = board/solver/engine side, slave = scheduler.
interface cube_move_if #(parameter int CNT_W = 8);
  import cube_pkg::*;

  logic             shuffle;
  logic [3:0]       random;
  logic             retain;
  logic             vblank;
  logic             sol_valid;
  move_t            sol_move;
  logic             sol_ready;
  logic             rot_valid;
  move_t            rot_move;
  logic             rot_done;
  logic             busy;
  logic [CNT_W-1:0] move_count;

  modport master (
    output shuffle, random, retain, vblank, sol_valid, sol_move, rot_done,
    input  sol_ready, rot_valid, rot_move, busy, move_count
  );

  modport slave (
    input  shuffle, random, retain, vblank, sol_valid, sol_move, rot_done,
    output sol_ready, rot_valid, rot_move, busy, move_count
  );

endinterface

// File: rtl/cube_move_scheduler_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used as the scramble move source.
module move_lfsr
  import cube_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign state_o = lfsr_q;

  // Load wins over shift so a fresh seed is never advanced on its first cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)    lfsr_q <= LFSR_RST;
    else if (load_i) lfsr_q <= load_val_i;
    else if (en_i)   lfsr_q <= {lfsr_q[6:0], fb};
  end

endmodule

// File: rtl/cube_move_scheduler.sv
// Cube move scheduler: arbitrates scramble vs solver moves and launches each
// move to the rotation engine, one at a time.
// Optional VBLANK_SYNC_EN: when defined, launches wait for vertical blanking;
// otherwise vblank is ignored and moves may launch during active video.
// reset_i is asynchronous, active low.
module cube_move_scheduler
  import cube_pkg::*;
#(
  parameter int SCRAMBLE_LEN = 20,
  parameter int CNT_W        = 8
)(
  input  logic        clk_i,
  input  logic        reset_i,
  cube_move_if.slave  bus
);

  state_e           state_q;
  move_t            rot_move_q, last_move_q;
  logic [7:0]       remaining_q;
  logic             rot_valid_q, busy_q;
  logic [CNT_W-1:0] count_q;
  logic             sh_q, sh_prev_q;

  logic             shuffle_edge, sol_fire, vb_ok;
  logic             lfsr_load, lfsr_en, cand_ok;
  logic [7:0]       lfsr;
  move_t            cand;

  // Register the button level and its previous value for edge detection.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sh_q      <= 1'b0;
      sh_prev_q <= 1'b0;
    end else begin
      sh_q      <= bus.shuffle;
      sh_prev_q <= sh_q;
    end
  end

  assign shuffle_edge = sh_q & ~sh_prev_q;

  // A scramble start in the same cycle steals the slot from the solver.
  assign bus.sol_ready = reset_i && (state_q == S_IDLE) && !bus.retain && !shuffle_edge;
  assign sol_fire      = bus.sol_valid && bus.sol_ready;

`ifdef VBLANK_SYNC_EN
  assign vb_ok = bus.vblank;
`else
  assign vb_ok = 1'b1;
`endif

  assign lfsr_load = (state_q == S_IDLE) && shuffle_edge;
  assign lfsr_en   = (state_q == S_GEN) && !bus.retain;
  assign cand      = lfsr[3:0];
  assign cand_ok   = move_valid(cand) && (cand != move_inv(last_move_q));

  move_lfsr u_lfsr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (lfsr_load),
    .load_val_i ({bus.random, ~bus.random}),
    .en_i       (lfsr_en),
    .state_o    (lfsr)
  );

  // Move sequencing FSM with registered launch pulse, busy and counters.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      rot_valid_q <= 1'b0;
      rot_move_q  <= '0;
      last_move_q <= MOVE_NONE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      rot_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (shuffle_edge) begin
            remaining_q <= 8'(SCRAMBLE_LEN);
            busy_q      <= 1'b1;
            state_q     <= S_GEN;
          end else if (sol_fire && move_valid(bus.sol_move)) begin
            rot_move_q  <= bus.sol_move;
            busy_q      <= 1'b1;
            state_q     <= S_WAIT_VB;
          end
        end
        S_GEN: begin
          // Retain freezes generation entirely; rejected candidates just
          // let the LFSR advance for another try next cycle.
          if (!bus.retain && cand_ok) begin
            rot_move_q  <= cand;
            remaining_q <= remaining_q - 8'd1;
            state_q     <= S_WAIT_VB;
          end
        end
        S_WAIT_VB: begin
          if (vb_ok && !bus.retain) begin
            rot_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (bus.rot_done) begin
            last_move_q <= rot_move_q;
            count_q     <= count_q + 1'b1;
            if (remaining_q != 8'd0) begin
              state_q <= S_GEN;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rot_valid  = rot_valid_q;
  assign bus.rot_move   = rot_move_q;
  assign bus.busy       = busy_q;
  assign bus.move_count = count_q;

endmodule

// File: tb/tb_cube_move_scheduler.sv
// Bench for cube_move_scheduler: solver vector table, scrambles checked
// against an arithmetic LFSR/move-selection model, retain and reset cases.
module tb_cube_move_scheduler;
  import cube_pkg::*;

  localparam int LEN = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cube_move_if #(.CNT_W(8)) bus ();

  cube_move_scheduler #(.SCRAMBLE_LEN(LEN), .CNT_W(8)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int exp_count = 0;
  logic [3:0] model_last = 4'hF;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  typedef struct {
    logic [3:0] mv;
    logic       vb;
    logic       launch;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next LFSR value from the polynomial: shift left, feed back tap parity.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    int fb;
    fb = $countones(s & 8'hB8) % 2;
    return 8'((s * 2 + fb) % 256);
  endfunction

  // Expected scramble sequence: walk the LFSR, keep codes < 12 that do not
  // undo the previous move.
  task automatic model_scramble(input logic [3:0] seed, input int n);
    logic [7:0] s;
    int prev, guard, c;
    s = {seed, ~seed};
    prev = model_last;
    guard = 0;
    exp_q.delete();
    while (exp_q.size() < n && guard < 100000) begin
      c = s % 16;
      s = lfsr_step(s);
      if (c < 12 && c != (prev ^ 1)) begin
        exp_q.push_back(c[3:0]);
        prev = c;
      end
      guard++;
    end
  endtask

  task automatic solver_move(input logic [3:0] mv, input logic vb, input logic launch);
    int t;
    t = 0;
    bus.vblank = vb; bus.sol_valid = 1'b1; bus.sol_move = mv;
    #1;
    while (!bus.sol_ready && t < 20) begin step(); t++; end
    check("sol_ready_idle", bus.sol_ready, 1);
    step();
    bus.sol_valid = 1'b0;
    check("no_launch_T1", bus.rot_valid, 0);
`ifdef VBLANK_SYNC_EN
    if (!vb && launch) begin
      repeat (100) begin
        step();
        check("held_for_vblank", bus.rot_valid, 0);
      end
      bus.vblank = 1'b1;
    end
`endif
    step();
    check("launch_T2", bus.rot_valid, launch);
    if (launch) begin
      check("rot_move", bus.rot_move, mv);
      check("busy_in_flight", bus.busy, 1);
      step();
      check("single_pulse", bus.rot_valid, 0);
      bus.rot_done = 1'b1;
      step();
      bus.rot_done = 1'b0;
      exp_count++;
      model_last = mv;
    end
    check("move_count", bus.move_count, exp_count % 256);
    check("busy_idle", bus.busy, 0);
  endtask

  // mode 0: plain, 1: retain after 7th launch, 2: random retain/shuffle/rot_done
  // abort_after != 0: return in WAIT_DONE after that many launches.
  task automatic run_scramble(input logic [3:0] seed, input int mode, input int abort_after);
    int budget, dly, hold;
    bit infl, done_drv, ret_prev;
    logic [3:0] cur;
    model_scramble(seed, LEN);
    got_q.delete();
    infl = 0; done_drv = 0; dly = 0; hold = 0; budget = 0; cur = 4'h0;
    bus.retain = 1'b0; bus.shuffle = 1'b0; bus.random = seed;
    step(); step();
    bus.shuffle = 1'b1;
    step();
    // Edge cycle: a competing solver offer must be refused.
    bus.sol_valid = 1'b1; bus.sol_move = 4'h3;
    #1;
    check("sol_ready_vs_shuffle", bus.sol_ready, 0);
    step();
    bus.sol_valid = 1'b0;
    check("busy_after_shuffle", bus.busy, 1);
    while ((got_q.size() < LEN || infl || bus.busy) && budget < 20000) begin
      ret_prev = bus.retain;
      step();
      budget++;
      if (done_drv) begin bus.rot_done = 1'b0; done_drv = 0; infl = 0; end
      if (bus.rot_valid) begin
        check("single_launch", infl, 0);
        check("launch_under_retain", ret_prev, 0);
        bus.rot_done = 1'b0;
        got_q.push_back(bus.rot_move);
        cur = bus.rot_move; infl = 1; dly = $urandom_range(0, 4);
        if (mode == 1 && got_q.size() == 7) begin bus.retain = 1'b1; hold = 60; end
        if (abort_after != 0 && got_q.size() == abort_after) begin
          step();
          return;
        end
      end else if (infl && !done_drv) begin
        check("rot_move_stable", bus.rot_move, cur);
        if (dly == 0) begin bus.rot_done = 1'b1; done_drv = 1; end
        else dly--;
      end else if (!infl && mode == 2) begin
        bus.rot_done = ($urandom_range(0, 5) == 0);
      end
      if (mode == 1 && hold > 0) begin
        hold--;
        if (hold == 0) bus.retain = 1'b0;
      end
      if (mode == 2) bus.retain = ($urandom_range(0, 3) == 0);
      if (mode == 2 && got_q.size() < LEN) bus.shuffle = 1'($urandom_range(0, 1));
      else bus.shuffle = 1'b0;
    end
    bus.rot_done = 1'b0; bus.shuffle = 1'b0; bus.retain = 1'b0;
    check("scramble_in_budget", budget < 20000, 1);
    check("launch_count", got_q.size(), LEN);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("move_seq", got_q[i], exp_q[i]);
      check("code_range", got_q[i] < 4'd12, 1);
      if (i > 0) check("no_inverse_pair", got_q[i] == (got_q[i-1] ^ 4'h1), 0);
    end
    exp_count += LEN;
    if (exp_q.size() == LEN) model_last = exp_q[LEN-1];
    check("scramble_count", bus.move_count, exp_count % 256);
    check("busy_falls", bus.busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'h3, 1'b1, 1'b1};
    tbl[1] = '{4'hD, 1'b1, 1'b0};
    tbl[2] = '{4'h0, 1'b1, 1'b1};
    tbl[3] = '{4'hB, 1'b0, 1'b1};
    tbl[4] = '{4'hC, 1'b1, 1'b0};
    tbl[5] = '{4'hF, 1'b0, 1'b0};
    tbl[6] = '{4'h6, 1'b1, 1'b1};
    tbl[7] = '{4'h1, 1'b1, 1'b1};

    bus.shuffle = 1'b0; bus.random = 4'h0; bus.retain = 1'b0; bus.vblank = 1'b0;
    bus.sol_valid = 1'b0; bus.sol_move = 4'h0; bus.rot_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sol_ready", bus.sol_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rot_valid", bus.rot_valid, 0);
    check("rst_rot_move", bus.rot_move, 0);
    check("rst_move_count", bus.move_count, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("sol_ready_after_rst", bus.sol_ready, 1);
    bus.retain = 1'b1; #1;
    check("sol_ready_retain", bus.sol_ready, 0);
    bus.retain = 1'b0; #1;

    for (int i = 0; i < 8; i++) solver_move(tbl[i].mv, tbl[i].vb, tbl[i].launch);

    run_scramble(4'h5, 0, 0);
    run_scramble(4'hA, 1, 0);
    for (int r = 0; r < 4; r++) run_scramble(4'($urandom_range(0, 15)), 2, 0);

    // Reset while a scramble move is in flight.
    run_scramble(4'h9, 0, 3);
    check("busy_before_reset", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_rot_valid", bus.rot_valid, 0);
    check("reset_move_count", bus.move_count, 0);
    check("reset_rot_move", bus.rot_move, 0);
    check("reset_sol_ready", bus.sol_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    exp_count = 0; model_last = 4'hF;
    step();
    run_scramble(4'h5, 0, 0);
    solver_move(4'h3, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
